window_controller: RTL and testbench

- Sequences window_generator for a raster pixel stream.
- Accepts pixels with a valid/ready handshake and frame-start marker, drives the generator's enable and data input, and tracks raster (x, y).
- Flags the cycles where the generator's window is fully populated inside the current frame, and presents those windows downstream with a valid/ready handshake and anchor coordinates.
- Sits between the pixel source and kernel blocks (filters, connected components).

---
 rtl/window_controller_if.sv | 30 +++
 rtl/window_controller.sv | 119 +++++++++++
 tb/tb_window_controller.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_controller_if.sv
// Pixel-in and window-out handshake bundle for window_controller.
// The master modport is the controller's view; slave is the surrounding source/sink.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

interface window_controller_if #(
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int X_BITS    = 11,
    parameter int Y_BITS    = 11
);
    logic                 in_valid;
    logic                 in_sof;
    logic [WORD_SIZE-1:0] in_data;
    logic                 in_ready;
    logic                 win_valid;
    logic                 win_ready;
    logic [X_BITS-1:0]    win_x;
    logic [Y_BITS-1:0]    win_y;

    modport master (
        input  in_valid, in_sof, in_data, win_ready,
        output in_ready, win_valid, win_x, win_y
    );

    modport slave (
        output in_valid, in_sof, in_data, win_ready,
        input  in_ready, win_valid, win_x, win_y
    );
endinterface

// File: rtl/window_controller.sv
// Raster sequencer for window_generator: tracks (x,y), flags fully populated in-frame windows.
// Latency: 1 cycle from pixel push to win_valid, aligned with the generator's registered dout.
// Backpressure: in_ready drops while a window is held unconsumed, freezing the generator.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef FRAME_WIDTH
`define FRAME_WIDTH 640
`endif
`ifndef FRAME_HEIGHT
`define FRAME_HEIGHT 480
`endif

module window_controller #(
    parameter int WORD_SIZE    = `WORD_SIZE,
    parameter int FRAME_WIDTH  = `FRAME_WIDTH,
    parameter int FRAME_HEIGHT = `FRAME_HEIGHT,
    parameter int WIDTH        = 3,
    parameter int HEIGHT       = 3,
    parameter int X_BITS       = 11,
    parameter int Y_BITS       = 11
) (
    input  logic                 clk,
    input  logic                 reset_n,
    window_controller_if.master  bus,
    output logic                 gen_en,
    output logic [WORD_SIZE-1:0] gen_din,
    output logic                 frame_done,
    output logic                 sync_err,
    output logic [15:0]          frame_count
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(FRAME_WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(FRAME_HEIGHT - 1);
    localparam logic [X_BITS-1:0] X_MIN  = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_MIN  = Y_BITS'(HEIGHT - 1);

    logic [0:0]        state;
    logic [X_BITS-1:0] x_cnt;
    logic [Y_BITS-1:0] y_cnt;
    logic [X_BITS-1:0] coord_x;
    logic [Y_BITS-1:0] coord_y;
    logic              in_ready;
    logic              push;
    logic              line_end;
    logic              last_px;
    logic              complete;

    logic              win_valid_q;
    logic [X_BITS-1:0] win_x_q;
    logic [Y_BITS-1:0] win_y_q;

    // A held window blocks new pixels so the generator never shifts under it.
    assign in_ready = !win_valid_q || bus.win_ready;
    assign push     = bus.in_valid && in_ready && (state == ACTIVE || bus.in_sof);

    // sof always restarts the raster, even mid-frame.
    assign coord_x  = bus.in_sof ? '0 : x_cnt;
    assign coord_y  = bus.in_sof ? '0 : y_cnt;
    assign line_end = (coord_x == X_LAST);
    assign last_px  = line_end && (coord_y == Y_LAST);

    // Columns that straddle a line wrap have x < WIDTH-1, so they are excluded here.
    assign complete = (coord_y >= Y_MIN) && (coord_x >= X_MIN);

    assign gen_en        = push;
    assign gen_din       = bus.in_data;
    assign bus.in_ready  = in_ready;
    assign bus.win_valid = win_valid_q;
    assign bus.win_x     = win_x_q;
    assign bus.win_y     = win_y_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (push) begin
            state <= last_px ? IDLE : ACTIVE;
            if (line_end) begin
                x_cnt <= '0;
                y_cnt <= last_px ? '0 : coord_y + Y_BITS'(1);
            end else begin
                x_cnt <= coord_x + X_BITS'(1);
                y_cnt <= coord_y;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_valid_q <= 1'b0;
            win_x_q     <= '0;
            win_y_q     <= '0;
        end else if (push) begin
            win_valid_q <= complete;
            win_x_q     <= coord_x;
            win_y_q     <= coord_y;
        end else if (win_valid_q && bus.win_ready) begin
            win_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= push && last_px;
            sync_err   <= push && bus.in_sof && (state == ACTIVE);
            if (push && last_px) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_window_controller.sv
// Scoreboard bench for window_controller on an 8x6 frame with a 3x3 window.
module tb_window_controller;
    localparam int WS = 8;
    localparam int FW = 8;
    localparam int FH = 6;
    localparam int W  = 3;
    localparam int H  = 3;
    localparam int XB = 11;
    localparam int YB = 11;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          gen_en;
    logic [WS-1:0] gen_din;
    logic          frame_done;
    logic          sync_err;
    logic [15:0]   frame_count;

    window_controller_if #(.WORD_SIZE(WS), .X_BITS(XB), .Y_BITS(YB)) bus ();

    window_controller #(
        .WORD_SIZE(WS), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
        .WIDTH(W), .HEIGHT(H), .X_BITS(XB), .Y_BITS(YB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .gen_en(gen_en),
        .gen_din(gen_din),
        .frame_done(frame_done),
        .sync_err(sync_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct { int x; int y; } win_t;
    win_t exp_q[$];

    // Reference model: a linear pixel index within the frame, not x/y registers.
    bit m_active = 0;
    int m_idx    = 0;
    bit m_full   = 0;
    bit m_fd     = 0;
    bit m_se     = 0;
    int m_frames = 0;
    int gen_cnt = 0, fd_cnt = 0, se_cnt = 0, overlap_cnt = 0, win_cnt = 0;

    always @(negedge clk or negedge reset_n) begin : model
        bit exp_rdy;
        bit push;
        int px, py;
        if (!reset_n) begin
            m_active = 0; m_idx = 0; m_full = 0; m_fd = 0; m_se = 0; m_frames = 0;
            exp_q.delete();
        end else begin
            exp_rdy = !m_full || bus.win_ready;
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("win_valid", 32'(bus.win_valid), 32'(m_full));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("sync_err", 32'(sync_err), 32'(m_se));
            if (m_fd) chk("frame_count", 32'(frame_count), 32'(m_frames % 65536));
            if (frame_done) fd_cnt++;
            if (sync_err) se_cnt++;
            if (frame_done && gen_en) overlap_cnt++;
            push = bus.in_valid && exp_rdy && (m_active || bus.in_sof);
            chk("gen_en", 32'(gen_en), 32'(push));
            m_fd = 0;
            m_se = 0;
            if (push) begin
                gen_cnt++;
                chk("gen_din", 32'(gen_din), 32'(bus.in_data));
                if (bus.in_sof) begin
                    if (m_active) m_se = 1;
                    m_idx = 0;
                    m_active = 1;
                end
                px = m_idx % FW;
                py = m_idx / FW;
                m_full = (px >= W - 1) && (py >= H - 1);
                if (m_full) exp_q.push_back('{x: px, y: py});
                m_idx++;
                if (m_idx == FW * FH) begin
                    m_active = 0; m_idx = 0; m_fd = 1; m_frames++;
                end
            end else if (m_full && bus.win_ready) begin
                m_full = 0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        win_t e;
        if (reset_n && bus.win_valid && bus.win_ready) begin
            if (exp_q.size() == 0) begin
                chk("win_unexpected", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("win_x", 32'(bus.win_x), 32'(e.x));
                chk("win_y", 32'(bus.win_y), 32'(e.y));
            end
            win_cnt++;
        end
    end

    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held by the driver
    int gap_pct  = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_mode == 0) bus.win_ready = 1'b1;
        else if (rdy_mode == 1) bus.win_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(bit sof, logic [WS-1:0] d);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            if (acc) return;
        end
        chk("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(int n);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'($urandom_range(0, 1));
        bus.in_data  = WS'($urandom);
        repeat (n) step();
        bus.in_sof = 1'b0;
    endtask

    task automatic do_hold();
        rdy_mode = 2;
        bus.win_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sof    = 1'b0;
        bus.in_data   = WS'($urandom);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_x", 32'(bus.win_x), 32'(4));
            chk("hold_y", 32'(bus.win_y), 32'(3));
            chk("hold_in_ready", 32'(bus.in_ready), 32'(0));
            chk("hold_gen_en", 32'(gen_en), 32'(0));
            step();
        end
        bus.win_ready = 1'b1;
        rdy_mode = 0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_win_valid", 32'(bus.win_valid), 32'(0));
        chk("rst_frame_count", 32'(frame_count), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #3 reset_n = 1'b1;
        step();
    endtask

    task automatic run_frame(int n_px, int hold_idx, int abort_idx);
        for (int i = 0; i < n_px; i++) begin
            send(i == 0, WS'($urandom));
            if (i == hold_idx + 1 && hold_idx >= 0) begin
                chk("release_x", 32'(bus.win_x), 32'(i % FW));
                chk("release_y", 32'(bus.win_y), 32'(i / FW));
                chk("release_valid", 32'(bus.win_valid), 32'(1));
            end
            if (i == hold_idx) do_hold();
            if (i == abort_idx) begin
                do_reset();
                return;
            end
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rdy_mode = 0;
        repeat (4) step();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int w0, g0, f0, s0, o0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = '0;
        bus.win_ready = 1'b1;
        #12;
        chk("reset_win_valid", 32'(bus.win_valid), 32'(0));
        chk("reset_frame_done", 32'(frame_done), 32'(0));
        chk("reset_sync_err", 32'(sync_err), 32'(0));
        chk("reset_frame_count", 32'(frame_count), 32'(0));
        chk("reset_win_xy", 32'({bus.win_x, bus.win_y}), 32'(0));
        chk("reset_in_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #3 reset_n = 1'b1;
        step();

        // single contiguous frame
        w0 = win_cnt; g0 = gen_cnt; f0 = fd_cnt;
        run_frame(48, -1, -1);
        drain();
        chk("s1_gen_cycles", 32'(gen_cnt - g0), 32'(48));
        chk("s1_windows", 32'(win_cnt - w0), 32'(24));
        chk("s1_frame_done", 32'(fd_cnt - f0), 32'(1));
        chk("s1_frame_count", 32'(frame_count), 32'(1));

        // pixels without sof are dropped while idle
        w0 = win_cnt; g0 = gen_cnt;
        for (int i = 0; i < 5; i++) send(1'b0, WS'($urandom));
        chk("s2_dropped", 32'(gen_cnt - g0), 32'(0));
        run_frame(48, -1, -1);
        drain();
        chk("s2_windows", 32'(win_cnt - w0), 32'(24));
        chk("s2_frame_count", 32'(frame_count), 32'(2));

        // downstream stall on window (4,3): pixel index 28
        w0 = win_cnt;
        run_frame(48, 28, -1);
        drain();
        chk("s3_windows", 32'(win_cnt - w0), 32'(24));
        chk("s3_frame_count", 32'(frame_count), 32'(3));

        // sof where (5,3) was expected, then a full frame
        w0 = win_cnt; f0 = fd_cnt; s0 = se_cnt;
        run_frame(29, -1, -1);
        run_frame(48, -1, -1);
        drain();
        chk("s4_sync_err", 32'(se_cnt - s0), 32'(1));
        chk("s4_frame_done", 32'(fd_cnt - f0), 32'(1));
        chk("s4_windows", 32'(win_cnt - w0), 32'(9 + 24));
        chk("s4_frame_count", 32'(frame_count), 32'(4));

        // back-to-back frames
        w0 = win_cnt; f0 = fd_cnt; o0 = overlap_cnt;
        run_frame(48, -1, -1);
        run_frame(48, -1, -1);
        drain();
        chk("s5_frame_done", 32'(fd_cnt - f0), 32'(2));
        chk("s5_overlap", 32'(overlap_cnt - o0), 32'(1));
        chk("s5_windows", 32'(win_cnt - w0), 32'(48));
        chk("s5_frame_count", 32'(frame_count), 32'(6));

        // asynchronous reset after pixel (3,4): index 35
        run_frame(48, -1, 35);
        g0 = gen_cnt;
        send(1'b0, WS'($urandom));
        chk("s6_idle_after_reset", 32'(gen_cnt - g0), 32'(0));
        w0 = win_cnt;
        run_frame(48, -1, -1);
        drain();
        chk("s6_windows", 32'(win_cnt - w0), 32'(24));
        chk("s6_frame_count", 32'(frame_count), 32'(1));

        // random gaps, random backpressure, stray sof strobes, one aborted frame
        gap_pct = 30;
        rdy_mode = 1;
        w0 = win_cnt; f0 = fd_cnt; s0 = se_cnt;
        for (int i = 0; i < 3; i++) send(1'b0, WS'($urandom));
        run_frame(20, -1, -1);
        for (int f = 0; f < 3; f++) begin
            rdy_mode = 1;
            run_frame(48, -1, -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        end
        drain();
        gap_pct = 0;
        chk("s7_frame_done", 32'(fd_cnt - f0), 32'(3));
        chk("s7_sync_err", 32'(se_cnt - s0), 32'(1));
        chk("s7_windows", 32'(win_cnt - w0), 32'(2 + 72));
        chk("s7_frame_count", 32'(frame_count), 32'(4));
        chk("s7_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
